uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: DEPTH, default 8, entries per requester FIFO; power of two, 2..64.
REQ-002 Port: i_Clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on i_Clock.
REQ-004 Port: i_A_wr  input  1  requester A write strobe, one byte per high cycle.
REQ-005 Port: i_A_data  input  8  requester A byte, qualified by i_A_wr.
REQ-006 Port: o_A_full  output  1  A FIFO holds DEPTH entries.
REQ-007 Port: o_A_ovf  output  1  sticky: A write dropped because FIFO full.
REQ-008 Port: i_B_wr / i_B_data / o_B_full / o_B_ovf  same as A ports, for requester B.
REQ-009 Port: o_Tx_DV  output  1  data-valid level to UART transmitter.
REQ-010 Port: o_Tx_Byte  output  8  byte presented to transmitter, stable while o_Tx_DV high.
REQ-011 Port: i_Tx_Done  input  1  transmitter done level; high from stop-bit end until o_Tx_DV is seen low.
REQ-012 Port: o_busy  output  1  either FIFO non-empty or FSM not in S_IDLE.
REQ-013 Port: o_grant  output  1  source of current/last byte: 0 = A, 1 = B.

Function
REQ-014 Each FIFO SHALL use registered read/write pointers one bit wider than log2(DEPTH), wrapping modulo 2*DEPTH.
- full = MSBs differ, lower bits equal.
- empty = pointers equal.
REQ-015 A write with FIFO full SHALL be dropped and set that port's ovf flag the next cycle. Full is evaluated before any same-cycle pop.
REQ-016 A write into an empty FIFO SHALL be visible as non-empty the next cycle. It is not eligible for grant in the cycle it is written.
REQ-017 FSM states:
- S_IDLE: o_Tx_DV = 0.
- S_SEND: o_Tx_DV = 1.
- S_RELEASE: o_Tx_DV = 0.
REQ-018 S_IDLE, at least one FIFO non-empty, i_Tx_Done = 0: grant a port, latch its head byte into o_Tx_Byte, pop it, update o_grant, go to S_SEND; all in one cycle.
REQ-019 Arbitration SHALL be round-robin:
- Both non-empty: grant the port opposite to o_grant.
- One non-empty: grant that port.
REQ-020 S_SEND SHALL hold o_Tx_DV = 1 and o_Tx_Byte stable until i_Tx_Done = 1, then go to S_RELEASE.
REQ-021 S_RELEASE SHALL hold o_Tx_DV = 0 until i_Tx_Done = 0, then go to S_IDLE.
REQ-022 Latency: i_A_wr at cycle N into empty idle block gives o_Tx_DV = 1 at cycle N+2.
REQ-023 Between consecutive bytes, o_Tx_DV SHALL be low for at least 2 cycles (S_RELEASE + S_IDLE).
REQ-024 Writes and pops on the same FIFO in the same cycle SHALL both take effect when the FIFO is neither empty nor full before the edge.
REQ-025 Simultaneous i_A_wr and i_B_wr SHALL both be accepted, each subject to its own full status.
REQ-026 Unused FSM encodings SHALL return to S_IDLE on the next cycle with o_Tx_DV = 0.

Reset
REQ-027 On reset, all outputs SHALL take these values the next cycle:
- o_Tx_DV = 0, o_Tx_Byte = 0x00.
- o_A_full = o_B_full = 0, o_A_ovf = o_B_ovf = 0.
- o_busy = 0, o_grant = 1, so A wins the first contested grant.
REQ-028 Reset SHALL empty both FIFOs and force S_IDLE. This includes mid-transfer: o_Tx_DV drops on the next edge and the in-flight byte is discarded.
REQ-029 Overflow flags SHALL clear only on reset.

Verification
REQ-030 Single byte: write A = 0x55 at cycle 0 → o_Tx_DV high at cycle 2 with o_Tx_Byte = 0x55. Model raises i_Tx_Done → DV low next cycle. Done low → o_busy = 0.
REQ-031 Round-robin: preload A = {0x01, 0x02}, B = {0x81, 0x82} while idle → transmitted order 0x01, 0x81, 0x02, 0x82; o_grant = 0, 1, 0, 1.
REQ-032 Overflow: write DEPTH+1 bytes to A with the transmitter stalled (Done never rises) → o_A_full = 1 after DEPTH writes; last byte dropped; o_A_ovf = 1.
REQ-033 Wrap-around: stream 3*DEPTH bytes 0x00..3*DEPTH-1 through B with one write per byte-time → all bytes sent in order, no ovf.
REQ-034 Reset mid-transfer: assert reset in S_SEND with 3 bytes queued → next cycle o_Tx_DV = 0, o_busy = 0, FIFOs empty, o_grant = 1.
REQ-035 Done handshake: hold i_Tx_Done = 1 while idle with A non-empty → no grant until Done falls; then o_Tx_DV = 1 the following cycle.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler feeding a UART transmitter.
// Per-port FIFOs, round-robin grant, DV/Done level handshake.
module uart_tx_sched_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       i_Clock,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic       ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [7:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        push;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign push  = wr && !full;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge i_Clock) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop && !empty) rptr <= rptr + ONE;
      if (wr && full) ovf <= 1'b1;
    end
  end
endmodule

module uart_tx_sched #(
  parameter int DEPTH = 8
) (
  input  logic       i_Clock,
  input  logic       reset,
  input  logic       i_A_wr,
  input  logic [7:0] i_A_data,
  output logic       o_A_full,
  output logic       o_A_ovf,
  input  logic       i_B_wr,
  input  logic [7:0] i_B_data,
  output logic       o_B_full,
  output logic       o_B_ovf,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  output logic       o_busy,
  output logic       o_grant
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       pop_a;
  logic       pop_b;
  logic       load;
  logic       sel_b;
  logic [7:0] a_head;
  logic [7:0] b_head;
  logic       a_empty;
  logic       b_empty;

  uart_tx_sched_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .i_Clock (i_Clock),
    .reset   (reset),
    .wr      (i_A_wr),
    .wdata   (i_A_data),
    .pop     (pop_a),
    .rdata   (a_head),
    .full    (o_A_full),
    .empty   (a_empty),
    .ovf     (o_A_ovf)
  );

  uart_tx_sched_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .i_Clock (i_Clock),
    .reset   (reset),
    .wr      (i_B_wr),
    .wdata   (i_B_data),
    .pop     (pop_b),
    .rdata   (b_head),
    .full    (o_B_full),
    .empty   (b_empty),
    .ovf     (o_B_ovf)
  );

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state     <= S_IDLE;
      o_Tx_Byte <= 8'h00;
      o_grant   <= 1'b1;
    end else begin
      state <= state_nx;
      if (load) begin
        o_Tx_Byte <= sel_b ? b_head : a_head;
        o_grant   <= sel_b;
      end
    end
  end

  // B wins only when A is empty or A was served last
  always_comb begin
    state_nx = state;
    pop_a    = 1'b0;
    pop_b    = 1'b0;
    load     = 1'b0;
    sel_b    = 1'b0;
    o_Tx_DV  = 1'b0;
    case (state)
      S_IDLE: begin
        if ((!a_empty || !b_empty) && !i_Tx_Done) begin
          load     = 1'b1;
          sel_b    = !b_empty && (a_empty || !o_grant);
          pop_a    = !sel_b;
          pop_b    = sel_b;
          state_nx = S_SEND;
        end
      end
      S_SEND: begin
        o_Tx_DV = 1'b1;
        if (i_Tx_Done) state_nx = S_RELEASE;
      end
      S_RELEASE: begin
        if (!i_Tx_Done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign o_busy = !a_empty || !b_empty || (state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: vector table plus
// hand sequences for overflow, wrap, reset and round-robin.
module tb_uart_tx_sched;
  localparam int DEPTH = 8;

  logic       i_Clock = 1'b0;
  logic       reset = 1'b1;
  logic       i_A_wr = 1'b0;
  logic [7:0] i_A_data = 8'h00;
  logic       o_A_full;
  logic       o_A_ovf;
  logic       i_B_wr = 1'b0;
  logic [7:0] i_B_data = 8'h00;
  logic       o_B_full;
  logic       o_B_ovf;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Done = 1'b0;
  logic       o_busy;
  logic       o_grant;

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(.DEPTH(DEPTH)) dut (
    .i_Clock   (i_Clock),
    .reset     (reset),
    .i_A_wr    (i_A_wr),
    .i_A_data  (i_A_data),
    .o_A_full  (o_A_full),
    .o_A_ovf   (o_A_ovf),
    .i_B_wr    (i_B_wr),
    .i_B_data  (i_B_data),
    .o_B_full  (o_B_full),
    .o_B_ovf   (o_B_ovf),
    .o_Tx_DV   (o_Tx_DV),
    .o_Tx_Byte (o_Tx_Byte),
    .i_Tx_Done (i_Tx_Done),
    .o_busy    (o_busy),
    .o_grant   (o_grant)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic       a_wr;
    logic [7:0] a_data;
    logic       b_wr;
    logic [7:0] b_data;
    logic       done;
    logic       e_dv;
    logic [7:0] e_byte;
    logic       e_grant;
    logic       e_busy;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic do_reset();
    i_A_wr = 1'b0;
    i_B_wr = 1'b0;
    i_Tx_Done = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Transmitter model: wait for DV, check byte, pulse Done
  task automatic xfer(input logic [7:0] eb, input logic eg,
                      input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_Tx_DV) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_dv_seen"}, int'(seen), 1);
    chk({name, "_byte"}, int'(o_Tx_Byte), int'(eb));
    chk({name, "_grant"}, int'(o_grant), int'(eg));
    i_Tx_Done = 1'b1;
    step();
    chk({name, "_dv_drop"}, int'(o_Tx_DV), 0);
    i_Tx_Done = 1'b0;
  endtask

  initial begin
    // single byte latency then Done-held-while-idle
    vt[0]  = '{1, 8'h55, 0, 8'h00, 0, 0, 8'h00, 1, 1};
    vt[1]  = '{0, 8'h00, 0, 8'h00, 0, 1, 8'h55, 0, 1};
    vt[2]  = '{0, 8'h00, 0, 8'h00, 0, 1, 8'h55, 0, 1};
    vt[3]  = '{0, 8'h00, 0, 8'h00, 1, 0, 8'h55, 0, 1};
    vt[4]  = '{0, 8'h00, 0, 8'h00, 1, 0, 8'h55, 0, 1};
    vt[5]  = '{0, 8'h00, 0, 8'h00, 0, 0, 8'h55, 0, 0};
    vt[6]  = '{1, 8'h3C, 0, 8'h00, 1, 0, 8'h55, 0, 1};
    vt[7]  = '{0, 8'h00, 0, 8'h00, 1, 0, 8'h55, 0, 1};
    vt[8]  = '{0, 8'h00, 0, 8'h00, 1, 0, 8'h55, 0, 1};
    vt[9]  = '{0, 8'h00, 0, 8'h00, 0, 1, 8'h3C, 0, 1};
    vt[10] = '{0, 8'h00, 0, 8'h00, 1, 0, 8'h3C, 0, 1};
    vt[11] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'h3C, 0, 0};

    do_reset();
    chk("rst_dv", int'(o_Tx_DV), 0);
    chk("rst_byte", int'(o_Tx_Byte), 0);
    chk("rst_afull", int'(o_A_full), 0);
    chk("rst_bfull", int'(o_B_full), 0);
    chk("rst_aovf", int'(o_A_ovf), 0);
    chk("rst_bovf", int'(o_B_ovf), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_grant", int'(o_grant), 1);

    for (int i = 0; i < 12; i++) begin
      i_A_wr    = vt[i].a_wr;
      i_A_data  = vt[i].a_data;
      i_B_wr    = vt[i].b_wr;
      i_B_data  = vt[i].b_data;
      i_Tx_Done = vt[i].done;
      step();
      chk($sformatf("v%0d_dv", i), int'(o_Tx_DV), int'(vt[i].e_dv));
      chk($sformatf("v%0d_byte", i), int'(o_Tx_Byte),
          int'(vt[i].e_byte));
      chk($sformatf("v%0d_grant", i), int'(o_grant),
          int'(vt[i].e_grant));
      chk($sformatf("v%0d_busy", i), int'(o_busy),
          int'(vt[i].e_busy));
    end
    i_A_wr = 1'b0;
    i_Tx_Done = 1'b0;

    // round-robin from reset: A first
    do_reset();
    i_A_wr = 1'b1; i_A_data = 8'h01;
    i_B_wr = 1'b1; i_B_data = 8'h81;
    step();
    i_A_data = 8'h02;
    i_B_data = 8'h82;
    step();
    i_A_wr = 1'b0;
    i_B_wr = 1'b0;
    chk("rr_first_dv", int'(o_Tx_DV), 1);
    chk("rr_first_byte", int'(o_Tx_Byte), 8'h01);
    chk("rr_first_grant", int'(o_grant), 0);
    i_Tx_Done = 1'b1;
    step();
    i_Tx_Done = 1'b0;
    xfer(8'h81, 1'b1, "rr1");
    xfer(8'h02, 1'b0, "rr2");
    xfer(8'h82, 1'b1, "rr3");
    step();
    step();
    chk("rr_busy_end", int'(o_busy), 0);

    // overflow with Done held so nothing is granted
    do_reset();
    i_Tx_Done = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf_notfull%0d", i), int'(o_A_full), 0);
      i_A_wr = 1'b1;
      i_A_data = 8'(8'h10 + i);
      step();
    end
    i_A_wr = 1'b0;
    chk("ovf_full", int'(o_A_full), 1);
    chk("ovf_pre", int'(o_A_ovf), 0);
    i_A_wr = 1'b1;
    i_A_data = 8'hEE;
    step();
    i_A_wr = 1'b0;
    chk("ovf_set", int'(o_A_ovf), 1);
    chk("ovf_b_clear", int'(o_B_ovf), 0);
    chk("ovf_no_dv", int'(o_Tx_DV), 0);
    i_Tx_Done = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      xfer(8'(8'h10 + i), 1'b0, $sformatf("ovf_drain%0d", i));
    step();
    step();
    chk("ovf_drained", int'(o_busy), 0);
    chk("ovf_sticky", int'(o_A_ovf), 1);
    chk("ovf_full_clr", int'(o_A_full), 0);

    // wrap-around through B
    do_reset();
    chk("wrap_ovf_rst", int'(o_A_ovf), 0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      i_B_wr = 1'b1;
      i_B_data = 8'(i);
      step();
      i_B_wr = 1'b0;
      xfer(8'(i), 1'b1, $sformatf("wrap%0d", i));
    end
    step();
    step();
    chk("wrap_bovf", int'(o_B_ovf), 0);
    chk("wrap_busy", int'(o_busy), 0);

    // reset in S_SEND with three bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i_A_wr = 1'b1;
      i_A_data = 8'(8'hA0 + i);
      step();
    end
    i_A_wr = 1'b0;
    chk("mid_dv", int'(o_Tx_DV), 1);
    chk("mid_byte", int'(o_Tx_Byte), 8'hA0);
    chk("mid_busy", int'(o_busy), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_dv", int'(o_Tx_DV), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_grant", int'(o_grant), 1);
    chk("mid_rst_byte", int'(o_Tx_Byte), 0);
    reset = 1'b0;
    step();
    step();
    chk("mid_after_dv", int'(o_Tx_DV), 0);
    chk("mid_after_busy", int'(o_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
